// File: rtl/jkff_bank_sched.sv
// jkff_bank_sched: round-robin command scheduler driving a JK flip-flop bank; define JKFF_SCHED_CHECK_EN to add a result check
module jkff_bank_sched #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [IDX_W-1:0] req0_idx,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [IDX_W-1:0] req1_idx,
    output logic             req1_ready,
    output logic [N-1:0]     j_out,
    output logic [N-1:0]     k_out,
    input  logic [N-1:0]     q_in,
    output logic             busy,
    output logic             done,
    output logic             done_src,
    output logic             done_q,
    output logic             bad_idx,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;
    state_t           state;
    logic             ptr;
    logic             src;
    logic [IDX_W-1:0] idx;
    logic             gnt0;
    logic             gnt1;
    logic [1:0]       sel_op;
    logic [IDX_W-1:0] sel_idx;
    logic [N-1:0]     sel_oh;
    logic [N-1:0]     cur_oh;
    logic             cur_q;
`ifdef JKFF_SCHED_CHECK_EN
    logic [1:0]       op;
    logic             old_q;
    logic             exp_q;
`endif

    // An index outside the bank maps to an all-zero select, so it can never drive a flop
    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] x);
        onehot = '0;
        for (int i = 0; i < N; i++) onehot[i] = (x == IDX_W'(i));
    endfunction

    // Grant while idle: pointer holder wins a tie, otherwise the sole valid requester
    always_comb begin
        gnt0    = reset && state == IDLE && req0_valid && (!ptr || !req1_valid);
        gnt1    = reset && state == IDLE && req1_valid && (ptr || !req0_valid);
        sel_op  = gnt1 ? req1_op : req0_op;
        sel_idx = gnt1 ? req1_idx : req0_idx;
        sel_oh  = onehot(sel_idx);
        cur_oh  = onehot(idx);
        cur_q   = |(q_in & cur_oh);
`ifdef JKFF_SCHED_CHECK_EN
        exp_q   = op == 2'b00 ? old_q : op == 2'b01 ? 1'b0 : op == 2'b10 ? 1'b1 : ~old_q;
`endif
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign busy       = state != IDLE;
`ifndef JKFF_SCHED_CHECK_EN
    assign err        = 1'b0;
`endif

    // Accept, drive J/K for exactly one edge, then report the settled Q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            src      <= 1'b0;
            idx      <= '0;
            j_out    <= '0;
            k_out    <= '0;
            done     <= 1'b0;
            done_src <= 1'b0;
            done_q   <= 1'b0;
            bad_idx  <= 1'b0;
`ifdef JKFF_SCHED_CHECK_EN
            op       <= 2'b00;
            old_q    <= 1'b0;
            err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    bad_idx <= 1'b0;
`ifdef JKFF_SCHED_CHECK_EN
                    err     <= 1'b0;
`endif
                    if (gnt0 || gnt1) begin
                        src   <= gnt1;
                        idx   <= sel_idx;
                        ptr   <= ~gnt1;
                        j_out <= sel_op[1] ? sel_oh : '0;
                        k_out <= sel_op[0] ? sel_oh : '0;
`ifdef JKFF_SCHED_CHECK_EN
                        op    <= sel_op;
                        old_q <= |(q_in & sel_oh);
`endif
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    j_out <= '0;
                    k_out <= '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    done     <= 1'b1;
                    done_src <= src;
                    done_q   <= cur_q;
                    bad_idx  <= ~|cur_oh;
`ifdef JKFF_SCHED_CHECK_EN
                    err      <= |cur_oh && cur_q != exp_q;
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jkff_bank_sched.sv
// tb_jkff_bank_sched: random and directed commands checked every cycle against a command-level model
module tb_jkff_bank_sched;
    localparam int N = 6;
`ifdef JKFF_SCHED_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
    logic [2:0] req0_idx = 3'd0, req1_idx = 3'd0;
    logic req0_ready, req1_ready;
    logic [N-1:0] j_out, k_out, q_in;
    logic busy, done, done_src, done_q, bad_idx, err;
    logic [N-1:0] bank = '0;
    logic [7:0] flip = '0;
    int checks = 0, errors = 0, cyc = 0;

    // Model state: one command record plus a count of edges since its acceptance
    int age = 0;
    bit ptr_m = 1'b0;
    bit c_src;
    logic [1:0] c_op;
    int c_idx;
    bit c_old, m_src, m_q, m_bad, m_err;
    logic [7:0] mq = '0;

    jkff_bank_sched #(.N(N), .IDX_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_idx(req0_idx), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_idx(req1_idx), .req1_ready(req1_ready),
        .j_out(j_out), .k_out(k_out), .q_in(q_in), .busy(busy), .done(done), .done_src(done_src),
        .done_q(done_q), .bad_idx(bad_idx), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign q_in = bank ^ flip[N-1:0];

    // Behavioural JK flop bank
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            case ({j_out[i], k_out[i]})
                2'b11: bank[i] <= ~bank[i];
                2'b10: bank[i] <= 1'b1;
                2'b01: bank[i] <= 1'b0;
                default: bank[i] <= bank[i];
            endcase

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick();
        if (req0_valid && req1_valid) return int'(ptr_m);
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit qview(input int i);
        return (i < N) ? (mq[i] ^ flip[i]) : 1'b0;
    endfunction

    function automatic bit rule(input logic [1:0] op, input bit old);
        case (op)
            2'b01: return 1'b0;
            2'b10: return 1'b1;
            2'b11: return ~old;
            default: return old;
        endcase
    endfunction

    // Reference model advances one command step per edge
    always @(posedge clk or negedge reset) begin
        int g;
        bit obs;
        if (!reset) begin
            age = 0;
            ptr_m = 1'b0;
        end else if (age == 1) begin
            if (c_idx < N) mq[c_idx] = rule(c_op, mq[c_idx]);
            age = 2;
        end else if (age == 2) begin
            m_src = c_src;
            m_bad = c_idx >= N;
            obs = qview(c_idx);
            m_q = obs;
            m_err = CHK && !m_bad && obs != rule(c_op, c_old);
            age = 3;
        end else begin
            g = pick();
            if (g >= 0) begin
                c_src = (g == 1);
                c_op = (g == 1) ? req1_op : req0_op;
                c_idx = int'((g == 1) ? req1_idx : req0_idx);
                c_old = qview(c_idx);
                ptr_m = (g == 0);
                age = 1;
            end else age = 0;
        end
    end

    // Compare every DUT output against the model each cycle
    always @(negedge clk) begin
        logic [7:0] oh;
        bit fr;
        int g;
        if (!reset) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_j", j_out, 0);
            chk("rst_k", k_out, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
        end else begin
            fr = (age == 0 || age == 3);
            g = pick();
            oh = 8'd1 << c_idx;
            chk("ready0", req0_ready, fr && g == 0);
            chk("ready1", req1_ready, fr && g == 1);
            chk("j_out", j_out, (age == 1 && (c_op == 2'b10 || c_op == 2'b11)) ? oh[N-1:0] : '0);
            chk("k_out", k_out, (age == 1 && (c_op == 2'b01 || c_op == 2'b11)) ? oh[N-1:0] : '0);
            chk("busy", busy, age == 1 || age == 2);
            chk("done", done, age == 3);
            if (age == 3) begin
                chk("done_src", done_src, m_src);
                chk("done_q", done_q, m_q);
                chk("bad_idx", bad_idx, m_bad);
                chk("err", err, m_err);
            end else begin
                chk("bad_idle", bad_idx, 0);
                chk("err_idle", err, 0);
            end
        end
    end

    task automatic send(input int s, input logic [1:0] op, input logic [2:0] idx);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (s == 0) begin req0_valid = 1'b1; req0_op = op; req0_idx = idx; end
        else begin req1_valid = 1'b1; req1_op = op; req1_idx = idx; end
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            got = (s == 0) ? req0_ready : req1_ready;
        end
        chk("send_accept", got, 1);
        @(posedge clk); #1;
        if (s == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic expect_done(input string nm, input bit s, input bit q, input bit b, input bit e);
        bit got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = done;
        end
        chk({nm, "_seen"}, got, 1);
        chk({nm, "_src"}, done_src, s);
        chk({nm, "_q"}, done_q, q);
        chk({nm, "_bad"}, bad_idx, b);
        chk({nm, "_err"}, err, e);
    endtask

    task automatic requester(input int s);
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(s, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bit srcs[4];
        int stamp[4];
        bit got;
        req0_valid = 1'b1; req0_op = 2'b10; req0_idx = 3'd2;
        repeat (2) @(negedge clk);
        chk("hold_rst_ready", req0_ready, 0);
        chk("hold_rst_j", j_out, 0);
        chk("hold_rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        req0_valid = 1'b0;

        send(0, 2'b10, 3'd2);
        @(negedge clk);
        chk("set2_j", j_out, 6'b000100);
        chk("set2_k", k_out, 0);
        expect_done("set2", 0, 1, 0, 0);

        send(1, 2'b10, 3'd5);
        expect_done("set5", 1, 1, 0, 0);
        send(1, 2'b11, 3'd5);
        @(negedge clk);
        chk("tog5_j", j_out, 6'b100000);
        chk("tog5_k", k_out, 6'b100000);
        expect_done("tog5a", 1, 0, 0, 0);
        send(1, 2'b11, 3'd5);
        expect_done("tog5b", 1, 1, 0, 0);

        send(0, 2'b10, 3'd3);
        expect_done("set3", 0, 1, 0, 0);
        send(0, 2'b00, 3'd3);
        @(negedge clk);
        chk("hold3_j", j_out, 0);
        chk("hold3_k", k_out, 0);
        expect_done("hold3", 0, 1, 0, 0);

        send(0, 2'b10, 3'd7);
        @(negedge clk);
        chk("bad7_j", j_out, 0);
        chk("bad7_k", k_out, 0);
        expect_done("bad7", 0, 0, 1, 0);

`ifdef JKFF_SCHED_CHECK_EN
        send(0, 2'b10, 3'd4);
        flip[4] = 1'b1;
        expect_done("force4", 0, 0, 0, 1);
        @(posedge clk); #1;
        flip = '0;
`endif

        send(0, 2'b10, 3'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_issue_j", j_out, 0);
        chk("rst_issue_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
        chk("rst_flop1", bank[1], 0);

        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 2'b10; req0_idx = 3'd0;
        req1_valid = 1'b1; req1_op = 2'b01; req1_idx = 3'd1;
        for (int d = 0; d < 4; d++) begin
            got = 1'b0;
            for (int n = 0; n < 10 && !got; n++) begin
                @(negedge clk);
                got = done;
            end
            chk("alt_seen", got, 1);
            srcs[d] = done_src;
            stamp[d] = cyc;
        end
        chk("alt_src0", srcs[0], 0);
        chk("alt_src1", srcs[1], 1);
        chk("alt_src2", srcs[2], 0);
        chk("alt_src3", srcs[3], 1);
        for (int d = 1; d < 4; d++) chk("alt_gap", stamp[d] - stamp[d-1], 3);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) @(posedge clk);

        fork
            requester(0);
            requester(1);
        join
        repeat (8) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jkff_bank_sched.md
Name: jkff_bank_sched

Overview:
- Command scheduler for a bank of N structural JK flip-flops (jkff_stru instances, shared clk).
- Two requesters issue hold/set/reset/toggle commands on one flop index each.
- The block round-robin arbitrates between them and drives the bank's J/K vectors for exactly one clock edge.
- It then reports completion with the resulting Q value.

Parameters:
N, 8, number of JK flip-flops in the bank (1..2**IDX_W)
IDX_W, 3, width of the flop index field

Ports:
clk  input  1  rising-edge clock, shared with the flop bank
reset  input  1  asynchronous, active-low reset (reset=0 resets)
req0_valid  input  1  requester 0 command valid
req0_op  input  2  requester 0 op: 00 hold, 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle
req0_idx  input  IDX_W  requester 0 target flop index
req0_ready  output  1  requester 0 command accepted this cycle
req1_valid, req1_op, req1_idx, req1_ready  same as requester 0, for requester 1
j_out  output  N  J inputs to flop bank
k_out  output  N  K inputs to flop bank
q_in  input  N  Q outputs from flop bank
busy  output  1  command in flight
done  output  1  one-cycle completion pulse
done_src  output  1  requester whose command completed
done_q  output  1  Q of the target flop after the command
bad_idx  output  1  with done: index was >= N, no drive performed
err  output  1  with done: Q mismatch (CHECK_EN only)

Behaviour:
- Reset (async, reset=0): state IDLE, rr pointer=req0, all outputs 0, including j_out and k_out. Any in-flight command is discarded with no done pulse. Reset takes effect immediately, not at the next edge.
- States: IDLE -> ISSUE -> SETTLE -> IDLE.
- IDLE:
  - If any valid, grant combinationally. If both are valid, the pointer holder wins; otherwise the sole valid wins.
  - reqX_ready=1 only for the granted requester, only in IDLE.
  - On the accepting edge: latch op, idx, src and old_q=q_in[idx]; pointer moves to the other requester; go to ISSUE.
  - ready=0 in all other states.
- ISSUE (1 cycle):
  - j_out/k_out are registered. Only bit idx is driven per op; all other bits are 0.
  - hold drives J=K=0.
  - If idx>=N, nothing is driven.
  - The flop bank samples at the edge leaving ISSUE. Go to SETTLE.
- SETTLE (1 cycle):
  - j_out=k_out=0.
  - At the edge leaving SETTLE, register done=1, done_src, done_q=q_in[idx] (0 if idx>=N), and bad_idx. Return to IDLE.
- done, bad_idx and err are high for exactly the first IDLE cycle after SETTLE. A new request may be accepted in that same cycle.
- Latency: done is visible 3 edges after the accepting edge's cycle start (accept edge + 2). Maximum throughput is one command per 3 cycles.
- busy=1 in ISSUE and SETTLE.
- Requests seen outside IDLE are ignored (no accept). Requesters must hold valid and fields stable until ready.
- j_out and k_out are never both driven on more than one bit.

Optional Feature:
- Macro: JKFF_SCHED_CHECK_EN.
- When defined:
  - At SETTLE, compute expected = hold: old_q, reset: 0, set: 1, toggle: ~old_q.
  - err=1 with done if q_in[idx] != expected.
  - err is never set for bad_idx commands.
- When undefined: no compare logic; err tied to 0.

Test Plan:
- Reset held low 2 cycles with req0_valid=1 -> ready=0, j_out=k_out=0, done=0. Release; req0 set idx=2 -> j_out=8'b00000100 for one cycle, done=1, done_src=0, done_q=1 two edges after accept.
- Flop 5 at 1, req1 toggle idx=5 -> k_out[5]=j_out[5]=1 in ISSUE only; done_q=0, err=0. A second toggle gives done_q=1.
- req0 and req1 both valid continuously (set idx0 / reset idx1) -> grants alternate 0,1,0,1. Each done is 3 cycles apart; done_src alternates.
- req0 hold idx=3 with flop 3 at 1 -> j_out=k_out=0 throughout; done_q=1, err=0.
- N=6: req0 set idx=7 -> no j/k activity; done=1, bad_idx=1, done_q=0, err=0.
- Reset asserted during ISSUE -> j_out clears immediately, no done pulse follows. With JKFF_SCHED_CHECK_EN, a forced q_in mismatch on set yields err=1 with done.
